// File: rtl/cmdreply.sv
// cmdreply: serializes read-reply / write-ack requests into framed bytes for the TX FIFO.
module cmdreply #(
   parameter logic [7:0] RD_HEADER = 8'h55,
   parameter logic [7:0] WR_HEADER = 8'haa,
   parameter logic       CHECKSUM  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_type,
   input  logic [7:0]  req_address,
   input  logic [7:0]  req_data,
   output logic [7:0]  out_data,
   output logic        out_wr,
   input  logic        out_full,
   output logic        busy,
   output logic [15:0] frames_sent
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR  = 3'd1;
   localparam logic [2:0] ADDR = 3'd2;
   localparam logic [2:0] DATA = 3'd3;
   localparam logic [2:0] CSUM = 3'd4;

   logic [2:0] state;
   logic       act_type, pend_type, pend_valid;
   logic [7:0] act_addr, act_data, pend_addr, pend_data, xr;
   logic       accept, last, load_req, load_pend, load, src_type;
   logic [7:0] src_addr, src_data, nxt_data;
   logic [2:0] nxt_state;

   assign req_ready = !pend_valid;
   assign accept    = req_valid && req_ready;
   assign out_wr    = (state != IDLE) && !out_full;
   assign busy      = (state != IDLE) || pend_valid;
   assign last      = out_wr && (state == CSUM || (!CHECKSUM && (state == DATA || (state == ADDR && act_type))));
   // pending is promoted at frame end, or from IDLE when it was filled on the final byte's cycle
   assign load_req  = (state == IDLE) && accept;
   assign load_pend = pend_valid && ((state == IDLE) || last);
   assign load      = load_req || load_pend;
   assign src_type  = load_pend ? pend_type : req_type;
   assign src_addr  = load_pend ? pend_addr : req_address;
   assign src_data  = load_pend ? pend_data : req_data;
   assign nxt_state = (state == HDR) ? ADDR : (state == ADDR && !act_type) ? DATA : CSUM;
   assign nxt_data  = (state == HDR) ? act_addr : (state == ADDR && !act_type) ? act_data : xr ^ out_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pend_valid  <= 1'b0;
         out_data    <= 8'h00;
         frames_sent <= 16'h0000;
         xr          <= 8'h00;
      end else begin
         if (accept && state != IDLE) begin
            pend_type  <= req_type;
            pend_addr  <= req_address;
            pend_data  <= req_data;
            pend_valid <= 1'b1;
         end
         if (load_pend) pend_valid <= 1'b0;
         if (last) frames_sent <= frames_sent + 16'd1;
         if (load) begin
            act_type <= src_type;
            act_addr <= src_addr;
            act_data <= src_data;
            out_data <= src_type ? WR_HEADER : RD_HEADER;
            xr       <= 8'h00;
            state    <= HDR;
         end else if (last) begin
            state <= IDLE;
         end else if (out_wr) begin
            xr       <= xr ^ out_data;
            out_data <= nxt_data;
            state    <= nxt_state;
         end
      end
   end
endmodule

// File: tb/tb_cmdreply.sv
// tb_cmdreply: directed self-checking bench for cmdreply (CHECKSUM=1 and CHECKSUM=0 instances).
module tb_cmdreply;
   logic        clk = 1'b0;
   logic        reset, req_valid, req_type, out_full;
   logic [7:0]  req_address, req_data;
   logic        req_ready, out_wr, busy;
   logic [7:0]  out_data;
   logic [15:0] frames_sent;
   logic        req_ready0, out_wr0, busy0;
   logic [7:0]  out_data0;
   logic [15:0] frames_sent0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmdreply dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_address(req_address), .req_data(req_data),
      .out_data(out_data), .out_wr(out_wr), .out_full(out_full),
      .busy(busy), .frames_sent(frames_sent)
   );

   cmdreply #(.CHECKSUM(1'b0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
      .req_type(req_type), .req_address(req_address), .req_data(req_data),
      .out_data(out_data0), .out_wr(out_wr0), .out_full(out_full),
      .busy(busy0), .frames_sent(frames_sent0)
   );

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_type = 1'b0; req_address = 8'h00; req_data = 8'h00; out_full = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr got %h exp 0", out_wr); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
      checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL reset_frames got %h exp 0000", frames_sent); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %h exp 1", req_ready); end
   endtask

   task automatic test_read;
      logic [7:0] exp [4] = '{8'h55, 8'hab, 8'h14, 8'hea};
      req_valid = 1'b1; req_type = 1'b0; req_address = 8'hab; req_data = 8'h14;
      @(negedge clk);
      req_valid = 1'b0; req_data = 8'hff;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_wr !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL read_byte%0d got wr=%h data=%h exp wr=1 data=%h", i, out_wr, out_data, exp[i]); end
         @(negedge clk);
      end
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL read_end_wr got %h exp 0", out_wr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy got %h exp 0", busy); end
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL read_frames got %h exp 0001", frames_sent); end
   endtask

   task automatic test_write;
      logic [7:0] exp [3] = '{8'haa, 8'hab, 8'h01};
      logic [15:0] f0;
      f0 = frames_sent0;
      req_valid = 1'b1; req_type = 1'b1; req_address = 8'hab; req_data = 8'h77;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_wr !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL write_byte%0d got wr=%h data=%h exp wr=1 data=%h", i, out_wr, out_data, exp[i]); end
         if (i < 2) begin
            checks++; if (out_wr0 !== 1'b1 || out_data0 !== exp[i]) begin errors++; $display("FAIL write_nocs_byte%0d got wr=%h data=%h exp wr=1 data=%h", i, out_wr0, out_data0, exp[i]); end
         end else begin
            checks++; if (out_wr0 !== 1'b0) begin errors++; $display("FAIL write_nocs_end got wr=%h exp 0", out_wr0); end
         end
         @(negedge clk);
      end
      checks++; if (out_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_end got wr=%h busy=%h exp 0 0", out_wr, busy); end
      checks++; if (frames_sent0 !== f0 + 16'd1) begin errors++; $display("FAIL write_nocs_frames got %h exp %h", frames_sent0, f0 + 16'd1); end
   endtask

   task automatic test_backpressure;
      req_valid = 1'b1; req_type = 1'b0; req_address = 8'h10; req_data = 8'h04;
      @(negedge clk);
      req_valid = 1'b0; req_address = 8'h99; req_data = 8'h99;
      checks++; if (out_wr !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL bp_hdr got wr=%h data=%h exp 1 55", out_wr, out_data); end
      @(negedge clk);
      out_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (out_wr !== 1'b0 || out_data !== 8'h10) begin errors++; $display("FAIL bp_stall%0d got wr=%h data=%h exp 0 10", i, out_wr, out_data); end
         @(negedge clk);
      end
      out_full = 1'b0;
      #1;
      checks++; if (out_wr !== 1'b1 || out_data !== 8'h10) begin errors++; $display("FAIL bp_addr got wr=%h data=%h exp 1 10", out_wr, out_data); end
      @(negedge clk);
      checks++; if (out_wr !== 1'b1 || out_data !== 8'h04) begin errors++; $display("FAIL bp_data got wr=%h data=%h exp 1 04", out_wr, out_data); end
      @(negedge clk);
      checks++; if (out_wr !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL bp_csum got wr=%h data=%h exp 1 41", out_wr, out_data); end
      @(negedge clk);
      checks++; if (out_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_end got wr=%h busy=%h exp 0 0", out_wr, busy); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [7] = '{8'h55, 8'hab, 8'h14, 8'hea, 8'haa, 8'hab, 8'h01};
      logic [15:0] f;
      f = frames_sent;
      req_valid = 1'b1; req_type = 1'b0; req_address = 8'hab; req_data = 8'h14;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %h exp 1", req_ready); end
      req_type = 1'b1; req_data = 8'h00;
      for (int i = 0; i < 7; i++) begin
         checks++; if (out_wr !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got wr=%h data=%h exp wr=1 data=%h", i, out_wr, out_data, exp[i]); end
         @(negedge clk);
         if (i == 0) begin
            req_valid = 1'b0;
            checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_pending got ready=%h busy=%h exp 0 1", req_ready, busy); end
         end
      end
      checks++; if (out_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end got wr=%h busy=%h exp 0 0", out_wr, busy); end
      checks++; if (frames_sent !== f + 16'd2) begin errors++; $display("FAIL b2b_frames got %h exp %h", frames_sent, f + 16'd2); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp [3] = '{8'haa, 8'hab, 8'h01};
      req_valid = 1'b1; req_type = 1'b0; req_address = 8'hab; req_data = 8'h14;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (out_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state got wr=%h busy=%h exp 0 0", out_wr, busy); end
      checks++; if (frames_sent !== 16'h0000 || out_data !== 8'h00) begin errors++; $display("FAIL rmid_regs got frames=%h data=%h exp 0000 00", frames_sent, out_data); end
      @(negedge clk);
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rmid_no_resume got wr=%h exp 0", out_wr); end
      req_valid = 1'b1; req_type = 1'b1; req_address = 8'hab;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_wr !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL rmid_byte%0d got wr=%h data=%h exp wr=1 data=%h", i, out_wr, out_data, exp[i]); end
         @(negedge clk);
      end
      checks++; if (out_wr !== 1'b0 || frames_sent !== 16'd1) begin errors++; $display("FAIL rmid_end got wr=%h frames=%h exp 0 0001", out_wr, frames_sent); end
   endtask

   task automatic test_wrap;
      force dut.frames_sent = 16'hffff;
      @(negedge clk);
      release dut.frames_sent;
      @(negedge clk);
      req_valid = 1'b1; req_type = 1'b1; req_address = 8'h3c;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_wr !== 1'b1 || out_data !== 8'h96 || frames_sent !== 16'hffff) begin errors++; $display("FAIL wrap_csum got wr=%h data=%h frames=%h exp 1 96 ffff", out_wr, out_data, frames_sent); end
      @(negedge clk);
      checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_frames got %h exp 0000", frames_sent); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cmdreply.md
Name: cmdreply

Overview:
Transmit-side counterpart of cmdparser. Takes reply requests from the register-access path: read results from a 0x55 read command, and acknowledges for a 0xaa write command. Serializes each request into a framed byte stream and writes it into the host-bound TX FIFO (fifo8_short write port), with full-flag backpressure. A one-entry pending buffer allows back-to-back frames with no idle cycles.

Parameters:
RD_HEADER, 8'h55, header byte of a read-reply frame
WR_HEADER, 8'haa, header byte of a write-ack frame
CHECKSUM, 1, 1 = append XOR checksum byte to every frame; 0 = no checksum byte

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  reply request present
req_ready  out  1  request accepted on a cycle where req_valid && req_ready
req_type  in  1  0 = read reply, 1 = write ack
req_address  in  8  register address being replied to
req_data  in  8  register read value; ignored for write ack
out_data  out  8  byte to TX FIFO
out_wr  out  1  TX FIFO write strobe (wrreq)
out_full  in  1  TX FIFO full flag
busy  out  1  frame in progress or request pending
frames_sent  out  16  count of fully emitted frames, wraps

Behaviour:
- Frames:
  - Read reply: RD_HEADER, address, data, [csum].
  - Write ack: WR_HEADER, address, [csum].
  - csum = XOR of all preceding bytes of the frame.
- Storage:
  - Active register {type, address, data}, plus state and running XOR.
  - Pending register with the same fields and a valid flag.
- req_ready = !pending_valid (registered flag, no combinational path from out_full).
- Acceptance:
  - Accepted request goes to the active register if state is IDLE, otherwise to the pending register.
  - If the active frame finishes in the same cycle, the new request is still written into pending.
- FSM states: IDLE, HDR, ADDR, DATA, CSUM.
  - IDLE -> HDR when the active register has just been loaded.
  - HDR -> ADDR on byte accept.
  - ADDR -> DATA (read) or ADDR -> CSUM (write, CHECKSUM=1) or ADDR -> frame end (write, CHECKSUM=0).
  - DATA -> CSUM (CHECKSUM=1) or DATA -> frame end.
  - CSUM -> frame end.
- Byte accept:
  - out_wr = (state != IDLE) && !out_full, combinational.
  - A byte is accepted exactly on cycles where out_wr = 1.
  - out_data is registered and valid whenever state != IDLE.
  - out_data holds its value while out_full = 1.
- Frame end (last byte accepted):
  - frames_sent increments by 1, wrapping 16'hffff -> 0.
  - If pending_valid: the pending entry moves to active, state goes to HDR next cycle (zero-gap), pending_valid clears.
  - Else state goes to IDLE.
- Latency:
  - Request accepted in IDLE at cycle N -> header visible with out_wr at N+1, provided out_full = 0.
  - Frame length at full rate is 4/3 cycles (read/write, CHECKSUM=1) or 3/2 cycles (CHECKSUM=0).
- busy = (state != IDLE) || pending_valid.
- Reset (any cycle, including mid-frame):
  - state = IDLE, pending_valid = 0, out_wr = 0 next cycle, out_data = 0, frames_sent = 0, running XOR = 0.
  - Any partial frame is abandoned and not resumed.
- req_data is sampled only at acceptance. Later changes on the request inputs do not affect the frame in flight.
- out_full asserted while in IDLE has no effect. out_full changing mid-frame only stalls; it never drops or duplicates bytes.

Test Plan:
1. Read reply, CHECKSUM=1, out_full = 0: request type 0, addr 8'hab, data 8'h14 -> out_wr on 4 consecutive cycles with 55, ab, 14, ea; frames_sent = 1; busy falls the cycle after the last byte.
2. Write ack, CHECKSUM=1: type 1, addr 8'hab -> bytes aa, ab, 01; with CHECKSUM=0 -> aa, ab only.
3. Backpressure: read reply 8'h10/8'h04 with out_full = 1 for 3 cycles while ADDR is presented -> out_wr = 0 those cycles, out_data stays 10, then 04 and 41 follow. No duplicate or lost bytes.
4. Back-to-back: read reply (ab, 14) then write ack (ab), both requested on consecutive cycles -> 7 bytes on 7 consecutive cycles (55 ab 14 ea aa ab 01). req_ready low while pending is full. frames_sent = 2.
5. Reset mid-frame: assert reset after the header of a read reply -> next cycle out_wr = 0, state IDLE, frames_sent = 0. A new write ack then emits a clean aa, ab, 01.
6. Counter wrap: force frames_sent = 16'hffff, complete one frame -> 16'h0000.
